// File: rtl/dump_resp_tx.sv
// Response stage behind the channel-dump sequencer: holds per-channel gain/offset,
// corrects a snapshotted RAM sample (offset, then gain, both saturating) and sends it as UART 8N1.
module dump_resp_tx #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flopGain,
  input  logic        flopOffset,
  input  logic [15:0] spiRXdata,
  input  logic        startUARTresp,
  input  logic [7:0]  rawSample,
  output logic        UARTrdy,
  output logic        TX,
  output logic [7:0]  txByte
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC1 = 3'd1,
    S_CALC2 = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

  // Offset is signed; the 10-bit sum covers -128..382 so bit 9 is a clean sign.
  function automatic logic [7:0] clamp_sum(input logic [7:0] raw, input logic [7:0] off);
    logic [9:0] sum;
    sum = {2'b00, raw} + {{2{off[7]}}, off};
    if (sum[9]) begin
      clamp_sum = 8'h00;
    end else if (sum[8]) begin
      clamp_sum = 8'hFF;
    end else begin
      clamp_sum = sum[7:0];
    end
  endfunction

  // Gain is Q1.7: 0x80 is unity, so the product is taken >> 7 and saturated.
  function automatic logic [7:0] scale_byte(input logic [7:0] s, input logic [7:0] g);
    logic [15:0] p;
    logic [8:0]  q;
    p = {8'h00, s} * {8'h00, g};
    q = p[15:7];
    if (q[8]) begin
      scale_byte = 8'hFF;
    end else begin
      scale_byte = q[7:0];
    end
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  gain_q, gain_d;
  logic [7:0]  off_q, off_d;
  logic [7:0]  raw_w_q, raw_w_d;
  logic [7:0]  gain_w_q, gain_w_d;
  logic [7:0]  off_w_q, off_w_d;
  logic [7:0]  sat_q, sat_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic        tx_q, tx_d;
  logic        rdy_q, rdy_d;
  logic [7:0]  txbyte_q, txbyte_d;
  logic [7:0]  scaled_s;
  logic        spi_hi_unused;

  assign scaled_s      = scale_byte(sat_q, gain_w_q);
  assign spi_hi_unused = ^spiRXdata[15:8];

  assign UARTrdy = rdy_q;
  assign TX      = tx_q;
  assign txByte  = txbyte_q;

  // State and datapath registers; reset drops TX high immediately, even mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gain_q   <= 8'h80;
      off_q    <= 8'h00;
      raw_w_q  <= 8'h00;
      gain_w_q <= 8'h00;
      off_w_q  <= 8'h00;
      sat_q    <= 8'h00;
      shift_q  <= 8'h00;
      cnt_q    <= 12'd0;
      bit_q    <= 3'd0;
      tx_q     <= 1'b1;
      rdy_q    <= 1'b1;
      txbyte_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      off_q    <= off_d;
      raw_w_q  <= raw_w_d;
      gain_w_q <= gain_w_d;
      off_w_q  <= off_w_d;
      sat_q    <= sat_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rdy_q    <= rdy_d;
      txbyte_q <= txbyte_d;
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    off_d    = off_q;
    raw_w_d  = raw_w_q;
    gain_w_d = gain_w_q;
    off_w_d  = off_w_q;
    sat_d    = sat_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rdy_d    = rdy_q;
    txbyte_d = txbyte_q;

    if (flopGain) begin
      gain_d = spiRXdata[7:0];
    end else begin
      gain_d = gain_q;
    end
    if (flopOffset) begin
      off_d = spiRXdata[7:0];
    end else begin
      off_d = off_q;
    end

    case (state_q)
      S_IDLE: begin
        if (startUARTresp) begin
          state_d  = S_CALC1;
          rdy_d    = 1'b0;
          raw_w_d  = rawSample;
          gain_w_d = gain_q;
          off_w_d  = off_q;
          cnt_d    = 12'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC1: begin
        sat_d   = clamp_sum(raw_w_q, off_w_q);
        state_d = S_CALC2;
      end
      S_CALC2: begin
        txbyte_d = scaled_s;
        shift_d  = scaled_s;
        tx_d     = 1'b0;
        cnt_d    = 12'd0;
        state_d  = S_START;
      end
      S_START: begin
        if (cnt_q == BAUD_LAST) begin
          state_d = S_DATA;
          cnt_d   = 12'd0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d = 12'd0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == BAUD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 12'd0;
          rdy_d   = 1'b1;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 12'd0;
        rdy_d   = 1'b1;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_dump_resp_tx.sv
// Bench for dump_resp_tx: directed and random frames checked against an arithmetic
// reference model and a bit-by-bit expected UART waveform.
module tb_dump_resp_tx;

  localparam int B = 4;

  logic        clk;
  logic        rst_n;
  logic        flopGain;
  logic        flopOffset;
  logic [15:0] spiRXdata;
  logic        startUARTresp;
  logic [7:0]  rawSample;
  logic        UARTrdy;
  logic        TX;
  logic [7:0]  txByte;

  int total = 0;
  int bad   = 0;
  logic [7:0] gain_m = 8'h80;
  logic [7:0] off_m  = 8'h00;

  dump_resp_tx #(.BAUD_DIV(B)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flopGain(flopGain),
    .flopOffset(flopOffset),
    .spiRXdata(spiRXdata),
    .startUARTresp(startUARTresp),
    .rawSample(rawSample),
    .UARTrdy(UARTrdy),
    .TX(TX),
    .txByte(txByte)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ref_byte(input logic [7:0] raw, input logic [7:0] g, input logic [7:0] o);
    int s;
    int q;
    s = int'(raw) + (o[7] ? int'(o) - 256 : int'(o));
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    q = (s * int'(g)) / 128;
    if (q > 255) q = 255;
    return 8'(q);
  endfunction

  task automatic chk8(input logic [7:0] obs, input logic [7:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input logic obs, input logic exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_coef(input logic g, input logic o, input logic [7:0] val);
    flopGain   = g;
    flopOffset = o;
    spiRXdata  = {8'($urandom), val};
    if (g) gain_m = val;
    if (o) off_m = val;
    @(posedge clk); #1;
    flopGain   = 1'b0;
    flopOffset = 1'b0;
    spiRXdata  = 16'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk1(TX, 1'b1, "idle_tx");
      chk1(UARTrdy, 1'b1, "idle_rdy");
      @(posedge clk); #1;
    end
  endtask

  // Called at a cycle where the DUT is idle; that cycle is N. Returns in the first idle cycle after the frame.
  task automatic frame(input logic [7:0] raw, input logic [7:0] exp, input int gp_at,
                       input logic [7:0] gval, input int rs_at, input int rst_at);
    logic [9:0] bits;
    bits = {1'b1, exp, 1'b0};
    startUARTresp = 1'b1;
    rawSample     = raw;
    chk1(UARTrdy, 1'b1, "rdy_at_start");
    for (int k = 1; k <= 10 * B + 2; k++) begin
      @(posedge clk); #1;
      startUARTresp = 1'b0;
      flopGain      = 1'b0;
      rawSample     = 8'($urandom);
      if (k == gp_at) begin
        flopGain  = 1'b1;
        spiRXdata = {8'hA5, gval};
        gain_m    = gval;
      end
      if (k == rs_at) startUARTresp = 1'b1;
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk1(TX, 1'b1, "rst_tx");
        chk1(UARTrdy, 1'b1, "rst_rdy");
        chk8(txByte, 8'h00, "rst_txbyte");
        #1 rst_n = 1'b1;
        gain_m = 8'h80;
        off_m  = 8'h00;
        @(posedge clk); #1;
        return;
      end
      chk1(UARTrdy, 1'b0, "rdy_busy");
      chk1(TX, (k < 3) ? 1'b1 : bits[(k - 3) / B], "tx_bit");
      if (k == 3) chk8(txByte, exp, "txbyte");
    end
    @(posedge clk); #1;
    flopGain      = 1'b0;
    startUARTresp = 1'b0;
    chk1(UARTrdy, 1'b1, "rdy_after");
    chk1(TX, 1'b1, "tx_after");
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] v;
    int mode;
    rst_n         = 1'b0;
    flopGain      = 1'b0;
    flopOffset    = 1'b0;
    spiRXdata     = 16'h0000;
    startUARTresp = 1'b0;
    rawSample     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk1(TX, 1'b1, "reset_tx");
    chk1(UARTrdy, 1'b1, "reset_rdy");
    chk8(txByte, 8'h00, "reset_txbyte");
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(2);

    // identity, offset saturation, gain path
    frame(8'h5A, 8'h5A, -1, 8'h00, -1, -1);
    set_coef(1'b0, 1'b1, 8'hF0);
    frame(8'h08, 8'h00, -1, 8'h00, -1, -1);
    set_coef(1'b0, 1'b1, 8'h20);
    frame(8'hF0, 8'hFF, -1, 8'h00, -1, -1);
    set_coef(1'b0, 1'b1, 8'h00);
    set_coef(1'b1, 1'b0, 8'hC0);
    frame(8'h64, 8'h96, -1, 8'h00, -1, -1);
    set_coef(1'b1, 1'b0, 8'hFF);
    frame(8'hFF, 8'hFF, -1, 8'h00, -1, -1);

    // snapshot isolation and ignored start while busy
    set_coef(1'b1, 1'b0, 8'h80);
    frame(8'h10, 8'h10, 1, 8'h40, 5, -1);
    idle(6);
    frame(8'h10, 8'h08, -1, 8'h00, -1, -1);

    // back-to-back frames
    frame(8'h81, ref_byte(8'h81, gain_m, off_m), -1, 8'h00, -1, -1);
    frame(8'h3C, ref_byte(8'h3C, gain_m, off_m), -1, 8'h00, -1, -1);

    // random coefficients and samples against the reference model
    for (int i = 0; i < 16; i++) begin
      mode = $urandom_range(0, 3);
      v    = 8'($urandom);
      if (mode == 0) set_coef(1'b1, 1'b0, v);
      if (mode == 1) set_coef(1'b0, 1'b1, v);
      if (mode == 2) set_coef(1'b1, 1'b1, v);
      r = 8'($urandom);
      frame(r, ref_byte(r, gain_m, off_m), -1, 8'h00, -1, -1);
      idle($urandom_range(0, 2));
    end

    // reset during data bit 3, then coefficients back at defaults
    set_coef(1'b1, 1'b0, 8'h40);
    set_coef(1'b0, 1'b1, 8'h10);
    frame(8'h77, ref_byte(8'h77, gain_m, off_m), -1, 8'h00, -1, 3 + 4 * B + 1);
    idle(2);
    frame(8'h33, 8'h33, -1, 8'h00, -1, -1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dump_resp_tx.md
Name: dump_resp_tx

Overview:
- Response stage directly downstream of the channel-dump sequencer.
- Captures per-channel gain and offset words from the EEPROM SPI read data when the sequencer strobes flopGain / flopOffset.
- On each startUARTresp, takes the raw RAM sample, applies offset then gain correction with saturation, and serialises the corrected byte to the host as UART 8N1.
- Drives UARTrdy back to the sequencer as its transmit handshake.

Parameters:
- BAUD_DIV, 2604: clk cycles per UART bit (100 MHz / 38400); legal range 2..4095.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flopGain  input  1  1-cycle strobe; capture spiRXdata[7:0] as the gain
- flopOffset  input  1  1-cycle strobe; capture spiRXdata[7:0] as the offset
- spiRXdata  input  16  EEPROM SPI read data, valid whenever a flop strobe is high
- startUARTresp  input  1  1-cycle strobe; correct and transmit rawSample
- rawSample  input  8  unsigned RAM sample for the selected channel, valid with startUARTresp
- UARTrdy  output  1  high when idle and able to accept startUARTresp
- TX  output  1  UART serial out, idle high
- txByte  output  8  corrected byte currently or last transmitted

Behaviour:
- Reset (asynchronous, rst_n low):
  - State = IDLE.
  - UARTrdy = 1, TX = 1, txByte = 0x00.
  - Gain register = 0x80 (unity), offset register = 0x00.
  - Baud counter, bit counter and pipeline registers are cleared.
  - Reset asserted mid-frame aborts the frame immediately: TX returns high in the same cycle reset is asserted.
- Coefficient capture:
  - flopGain writes gain <= spiRXdata[7:0]; flopOffset writes offset <= spiRXdata[7:0].
  - Capture is legal in any state.
  - If both strobes are high in the same cycle, both registers load from the same data.
- Snapshot:
  - A startUARTresp accepted in IDLE (cycle N) latches rawSample, gain and offset into working registers.
  - Coefficient writes after cycle N do not affect that frame.
  - startUARTresp while not in IDLE is ignored; no queueing.
- Arithmetic:
  - Offset is signed two's complement 8-bit.
  - Stage 1 (CALC1, registered at N+1): sum = raw + sign-extended offset, 10-bit signed. Clamp sum < 0 to 0 and sum > 255 to 255, giving s[7:0].
  - Stage 2 (CALC2, registered at N+2): p = s * gain, 16-bit unsigned; q = p >> 7, 9-bit.
  - txByte = 255 if q > 255, else q[7:0].
  - Gain 0x80 is unity and 0xFF is approximately 2x.
- UARTrdy:
  - Falls at N+1 (registered) and stays low through the end of the stop bit.
  - Returns high on the cycle after the last stop-bit cycle.
- States and transitions:
  - IDLE -> CALC1 on startUARTresp.
  - CALC1 -> CALC2.
  - CALC2 -> START; load the bit shifter with txByte.
  - START: TX = 0 for BAUD_DIV cycles, then -> DATA.
  - DATA: TX = shifter[0] (LSB first); shift right every BAUD_DIV cycles. After 8 bits (bit counter wraps 7 -> 0) -> STOP.
  - STOP: TX = 1 for BAUD_DIV cycles, then -> IDLE.
- Timing:
  - The start bit begins at cycle N+3.
  - A full frame occupies 10*BAUD_DIV cycles.
  - Total busy time is 10*BAUD_DIV + 2 cycles.
- Baud counter:
  - Counts 0..BAUD_DIV-1, clears on every state entry and on wrap.
  - A bit period ends when count == BAUD_DIV-1.
- Back-to-back frames: startUARTresp in the first IDLE cycle after STOP is accepted. The stop bit is never shortened.

Test Plan:
- Identity and timing: BAUD_DIV=4, reset, no coefficient writes, rawSample=0x5A, startUARTresp -> txByte=0x5A; start bit at N+3; TX frame 0,0,1,0,1,1,0,1,0,1 per 4 cycles; UARTrdy low N+1..N+42.
- Offset saturation: offset=0xF0 (-16), raw=0x08 -> txByte=0x00; offset=0x20, raw=0xF0 -> txByte=0xFF.
- Gain path: gain=0xC0, offset=0x00, raw=0x64 -> 100*192>>7=150 -> txByte=0x96; gain=0xFF, raw=0xFF -> 0xFF (clamped from 508).
- Snapshot isolation:
  - Start with gain=0x80, raw=0x10, then pulse flopGain with 0x40 at N+1 -> txByte=0x10.
  - The next frame with raw=0x10 -> txByte=0x08.
  - startUARTresp at N+5 is ignored: only one frame appears on TX.
- Reset mid-frame: assert rst_n low during DATA bit 3 -> TX=1 and UARTrdy=1 immediately; gain reads back as unity on the next frame (raw 0x33 -> 0x33).
- Back-to-back: startUARTresp on the first IDLE cycle after STOP -> second start bit begins exactly 3 cycles later; the first stop bit is a full BAUD_DIV cycles.
